// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU controller.
package alu_pkg;

    // Operand/result width used when the instantiating code does not override it.
    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpXor = 3'b010,
        OpNot = 3'b011,
        OpAdd = 3'b100,
        OpSub = 3'b101,
        OpShl = 3'b110,
        OpShr = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StShift,
        StDone
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle evaluation of logic, add and subtract ops with flags.
// Shift ops pass A through unchanged; that value is only used for a zero shift amount.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  alu_op_e          op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int unsigned Msb = Width - 1;

    logic [Width:0] sum;
    logic [Width:0] diff;

    // Decode the opcode into result, carry (or borrow) and signed overflow.
    always_comb begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        // Top bit of the extended difference is the borrow out.
        diff       = {1'b0, a_i} - {1'b0, b_i};
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        unique case (op_i)
            OpAnd: result_o = a_i & b_i;
            OpOr:  result_o = a_i | b_i;
            OpXor: result_o = a_i ^ b_i;
            OpNot: result_o = ~a_i;
            OpAdd: begin
                result_o   = sum[Width-1:0];
                carry_o    = sum[Width];
                overflow_o = (a_i[Msb] == b_i[Msb]) && (sum[Msb] != a_i[Msb]);
            end
            OpSub: begin
                result_o   = diff[Width-1:0];
                carry_o    = diff[Width];
                overflow_o = (a_i[Msb] != b_i[Msb]) && (diff[Msb] != a_i[Msb]);
            end
            OpShl, OpShr: result_o = a_i;
            default: ;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: valid/ready command intake, one-cycle execute for
// non-shift ops, bit-serial shifts (one position per cycle), held result until taken.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned ShW = $clog2(WIDTH);

    alu_state_e       state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [ShW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             overflow_q;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_zero;
    logic             core_overflow;

    logic [ShW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] shift_next;
    logic             shift_out;

    assign shamt    = b_q[ShW-1:0];
    assign is_shift = (op_q == OpShl) || (op_q == OpShr);

    alu_core #(
        .Width(WIDTH)
    ) u_core (
        .op_i      (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .result_o  (core_result),
        .carry_o   (core_carry),
        .zero_o    (core_zero),
        .overflow_o(core_overflow)
    );

    // One-position shift of the working register and the bit that falls off the end.
    always_comb begin
        shift_next = work_q;
        shift_out  = 1'b0;
        if (op_q == OpShl) begin
            shift_next = work_q << 1;
            shift_out  = work_q[WIDTH-1];
        end else begin
            shift_next = work_q >> 1;
            shift_out  = work_q[0];
        end
    end

    // Control FSM with operand capture, shift counter and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpAnd;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q    <= alu_op_e'(op);
                        a_q     <= A;
                        b_q     <= B;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_shift && (shamt != '0)) begin
                        work_q  <= a_q;
                        cnt_q   <= shamt;
                        state_q <= StShift;
                    end else begin
                        result_q   <= core_result;
                        carry_q    <= core_carry;
                        zero_q     <= core_zero;
                        overflow_q <= core_overflow;
                        state_q    <= StDone;
                    end
                end
                StShift: begin
                    work_q <= shift_next;
                    cnt_q  <= cnt_q - ShW'(1);
                    // Last shift: publish directly so DONE follows the n-th shift edge.
                    if (cnt_q == ShW'(1)) begin
                        result_q   <= shift_next;
                        carry_q    <= shift_out;
                        zero_q     <= (shift_next == '0);
                        overflow_q <= 1'b0;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_seq_ctrl;

    localparam int W    = 4;
    localparam int Mask = (1 << W) - 1;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op        = '0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         overflow;

    int n_vec   = 0;
    int n_err   = 0;
    bit tb_done = 1'b0;

    alu_seq_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result packed as {overflow, carry, zero, result}.
    function automatic logic [W+2:0] model_op(input int o, input int a, input int b);
        int r, n, sa, sb, s;
        bit c, v;
        n  = b % W;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (o)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~a;
            4: begin
                r = a + b;
                c = (r > Mask);
                s = sa + sb;
                v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            5: begin
                r = a - b;
                c = (a < b);
                s = sa - sb;
                v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            6: begin
                r = a << n;
                c = (n > 0) ? ((a >> (W - n)) & 1) != 0 : 1'b0;
            end
            7: begin
                r = a >> n;
                c = (n > 0) ? ((a >> (n - 1)) & 1) != 0 : 1'b0;
            end
            default: r = 0;
        endcase
        r = r & Mask;
        return {v, c, (r == 0), r[W-1:0]};
    endfunction

    // Edge (counting from the accept edge) at which out_valid is first sampled high.
    function automatic int latency(input int o, input int b);
        int n;
        n = b % W;
        return (o >= 6 && n > 0) ? n + 2 : 2;
    endfunction

    // Transaction-level model: idle, busy for a number of edges, or holding a result.
    bit           m_init = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_chk  = 1'b0;
    int           m_left = 0;
    logic [W+2:0] m_exp  = '0;
    logic [W+2:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_chk  <= 1'b1;
            m_exp  <= '0;
        end else if (m_done) begin
            if (out_ready) begin
                m_done <= 1'b0;
                m_chk  <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_exp  <= m_pend;
                m_chk  <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_left <= latency(int'(op), int'(B)) - 1;
            m_pend <= model_op(int'(op), int'(A), int'(B));
            m_chk  <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init && !tb_done) begin
            chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy && !m_done));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_done));
            if (m_chk) begin
                chk("cyc_result", 32'(result), 32'(m_exp[W-1:0]));
                chk("cyc_zero", 32'(zero), 32'(m_exp[W]));
                chk("cyc_carry", 32'(carry), 32'(m_exp[W+1]));
                chk("cyc_overflow", 32'(overflow), 32'(m_exp[W+2]));
            end
        end
    end

    // Issue one command from IDLE, scramble inputs after accept, check literals and latency.
    task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input bit ec,
                         input bit ez, input bit ev, input int elat);
        int edges;
        op        = o;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        A        = W'($urandom);
        B        = W'($urandom);
        edges    = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, "_latency"}, 32'(edges + 1), 32'(elat));
        chk({name, "_result"}, 32'(result), 32'(er));
        chk({name, "_carry"}, 32'(carry), 32'(ec));
        chk({name, "_zero"}, 32'(zero), 32'(ez));
        chk({name, "_overflow"}, 32'(overflow), 32'(ev));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int edges;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({carry, zero, overflow}), 32'd0);
        rst = 1'b0;

        // Pin the reference model to hand-computed values.
        chk("model_or", 32'(model_op(1, 12, 3)), 32'h0F);
        chk("model_add_ovf", 32'(model_op(4, 7, 1)), 32'h48);
        chk("model_add_carry", 32'(model_op(4, 15, 1)), 32'h30);
        chk("model_sub_borrow", 32'(model_op(5, 3, 5)), 32'h2E);
        chk("model_sub_zero", 32'(model_op(5, 5, 5)), 32'h10);
        chk("model_shl", 32'(model_op(6, 3, 2)), 32'h0C);
        chk("model_shr", 32'(model_op(7, 1, 1)), 32'h30);
        chk("model_shl_lat", 32'(latency(6, 2)), 32'd4);

        do_op("or",      3'b001, 4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0, 2);
        do_op("add_ovf", 3'b100, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 2);
        do_op("add_cy",  3'b100, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2);
        do_op("sub_bw",  3'b101, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0, 2);
        do_op("sub_eq",  3'b101, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0, 2);
        do_op("shl",     3'b110, 4'b0011, 4'b0010, 4'b1100, 1'b0, 1'b0, 1'b0, 4);
        do_op("shr",     3'b111, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 3);
        do_op("shl_0",   3'b110, 4'b1011, 4'b0100, 4'b1011, 1'b0, 1'b0, 1'b0, 2);
        do_op("not",     3'b011, 4'b1010, 4'b0110, 4'b0101, 1'b0, 1'b0, 1'b0, 2);

        // Result held in DONE under back-pressure while a new command waits.
        op       = 3'b100;
        A        = 4'b0111;
        B        = 4'b0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b1;
        op       = 3'b000;
        A        = '0;
        B        = '0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_result", 32'(result), 32'h8);
            chk("hold_overflow", 32'(overflow), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a three-position shift.
        op       = 3'b110;
        A        = 4'b0001;
        B        = 4'b0011;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_shift_out_valid", 32'(out_valid), 32'd0);
        chk("rst_shift_result", 32'(result), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_shift_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic including occasional resets and back-pressure.
        repeat (400) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            op        = 3'($urandom);
            A         = W'($urandom);
            B         = W'($urandom);
            @(posedge clk);
            #1;
        end

        tb_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (power of two, >=4).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  block can accept a command.
REQ-006 SHALL have port op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 ADD, 101 SUB (A-B), 110 SHL, 111 SHR (logical).
REQ-007 SHALL have ports A, B  input  WIDTH  operands; shift amount = B[log2(WIDTH)-1:0].
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have ports carry, zero, overflow  output  1 each  registered flags.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, SHIFT, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept = in_valid & in_ready at a rising edge; op, A, B SHALL be captured then; later input changes SHALL be ignored until next accept.
REQ-015 IDLE -> EXEC on accept; otherwise stay IDLE.
REQ-016 EXEC: non-shift ops, or shifts with amount 0, SHALL register result/flags and go to DONE (out_valid high 2 edges after accept edge).
REQ-017 EXEC: shifts with amount n>0 SHALL load working register with A and go to SHIFT; SHIFT SHALL shift one bit per cycle for n cycles, then DONE (out_valid high n+2 edges after accept edge).
REQ-018 DONE SHALL hold result and flags stable while out_ready=0; on out_ready=1 -> IDLE; no command accepted in the same cycle.
REQ-019 ADD: result = (A+B) mod 2^WIDTH; carry = carry-out; overflow = signed two's-complement overflow.
REQ-020 SUB: result = (A-B) mod 2^WIDTH; carry = borrow (1 when A<B unsigned); overflow = signed overflow.
REQ-021 Logic ops (AND/OR/XOR/NOT): carry = 0, overflow = 0.
REQ-022 Shifts: zero-fill; carry = last bit shifted out, 0 when amount 0; overflow = 0.
REQ-023 zero SHALL equal (result == 0) for every op.

Reset
REQ-024 With rst=1 at an edge: state IDLE, result 0, carry/zero/overflow 0, shift counter 0, out_valid 0.
REQ-025 rst SHALL take priority over any handshake in the same cycle; no command accepted while rst=1.
REQ-026 rst in EXEC/SHIFT/DONE SHALL discard the operation; in_ready=1 the cycle after rst deasserts.

Structure
REQ-027 Shared package alu_pkg SHALL hold opcode enum, FSM state enum, default WIDTH constant.
REQ-028 Combinational op evaluation (logic, add, sub, flags) SHALL live in sub-module alu_core; alu_seq_ctrl holds FSM, capture registers, shift counter, output registers.

Verification
REQ-029 OR A=1100 B=0011 -> result 1111, zero 0, carry 0, out_valid 2 edges after accept.
REQ-030 ADD 0111+0001 -> 1000, overflow 1, carry 0; ADD 1111+0001 -> 0000, carry 1, zero 1.
REQ-031 SUB 0011-0101 -> 1110, carry 1, overflow 0; SUB 0101-0101 -> 0000, zero 1.
REQ-032 SHL A=0011 B=0010 -> 1100, carry 0, out_valid 4 edges after accept; SHR A=0001 B=0001 -> 0000, carry 1, zero 1.
REQ-033 out_ready=0 for 5 cycles in DONE with in_valid=1 -> result/flags stable, in_ready 0, no accept; out_ready=1 -> IDLE next edge.
REQ-034 rst=1 during SHIFT (SHL 0001 by 11) -> next cycle out_valid 0, result 0, in_ready 1 after rst deasserts.
